// File: rtl/ttc_chanb_transmitter.sv
// TTC Channel B short-broadcast transmitter: queues trigger-control requests,
// builds Hamming-protected frames and serializes them one bit per bit_en.
module ttc_chanb_transmitter #(
   parameter int GAP_BITS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bit_en,
   input  logic        req_evt_count_reset,
   input  logic        req_counter_reset,
   input  logic        req_fill_type,
   input  logic [1:0]  fill_type_sel,
   input  logic        req_pulse_storage,
   input  logic        pulse_storage_start,
   output logic        chan_b_serial,
   output logic        busy,
   output logic [7:0]  sent_cmd,
   output logic        sent_valid,
   output logic [31:0] frame_count,
   output logic [31:0] overwrite_count
);

   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t        state, state_nxt;
   logic          ecr_p, cr_p, ft_p, ps_p;
   logic [1:0]    ft_sel;
   logic          ps_start;
   logic [15:0]   frame_q;
   logic [3:0]    bit_idx;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    base_cmd, brcst;
   logic [15:0]   load_frame;
   logic          any_pend, load, last_bit;
   logic          clr_cr, clr_ft, clr_ps;
   logic [2:0]    ow_hits;
   logic [32:0]   ow_sum;

   // start, fmt, data msb-first, h4..h0, stop
   function automatic logic [15:0] build_frame(input logic [7:0] d);
      logic [4:0] h;
      h[0] = d[0] ^ d[1] ^ d[2] ^ d[3];
      h[1] = d[0] ^ d[4] ^ d[5] ^ d[6];
      h[2] = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
      h[3] = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7];
      h[4] = ^{d, h[3:0]};
      return {2'b00, d, h, 1'b1};
   endfunction

   always_comb begin
      base_cmd = 8'h00;
      if (cr_p)
         base_cmd = 8'h28;
      else if (ft_p)
         base_cmd = {1'b1, ft_sel, 5'b0};
      else if (ps_p)
         base_cmd = ps_start ? 8'h88 : 8'hA8;
      brcst      = base_cmd | (ecr_p ? 8'h02 : 8'h00);
      load_frame = build_frame(brcst);
      any_pend   = ecr_p | cr_p | ft_p | ps_p;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last_bit  = 1'b0;
      unique case (state)
         IDLE:
            if (bit_en && any_pend) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         SHIFT:
            if (bit_en && bit_idx == 4'd0) begin
               last_bit  = 1'b1;
               state_nxt = GAP;
            end
         GAP:
            if (bit_en && gap_cnt == GAP_LAST)
               state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign clr_cr = load & cr_p;
   assign clr_ft = load & ~cr_p & ft_p;
   assign clr_ps = load & ~cr_p & ~ft_p & ps_p;

   always_comb begin
      ow_hits = 3'(req_evt_count_reset & ecr_p) + 3'(req_counter_reset & cr_p)
              + 3'(req_fill_type & ft_p) + 3'(req_pulse_storage & ps_p);
      ow_sum  = {1'b0, overwrite_count} + 33'(ow_hits);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // a request coinciding with its clear wins, so it stays pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ecr_p           <= 1'b0;
         cr_p            <= 1'b0;
         ft_p            <= 1'b0;
         ps_p            <= 1'b0;
         ft_sel          <= 2'b00;
         ps_start        <= 1'b0;
         overwrite_count <= 32'd0;
      end else begin
         ecr_p <= req_evt_count_reset | (ecr_p & ~load);
         cr_p  <= req_counter_reset | (cr_p & ~clr_cr);
         ft_p  <= req_fill_type | (ft_p & ~clr_ft);
         ps_p  <= req_pulse_storage | (ps_p & ~clr_ps);
         if (req_fill_type)
            ft_sel <= fill_type_sel;
         if (req_pulse_storage)
            ps_start <= pulse_storage_start;
         overwrite_count <= ow_sum[32] ? 32'hFFFF_FFFF : ow_sum[31:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chan_b_serial <= 1'b1;
         frame_q       <= 16'h0000;
         bit_idx       <= 4'd0;
         gap_cnt       <= '0;
         sent_cmd      <= 8'h00;
         sent_valid    <= 1'b0;
         frame_count   <= 32'd0;
      end else begin
         sent_valid <= 1'b0;
         if (load) begin
            frame_q       <= load_frame;
            chan_b_serial <= load_frame[15];
            bit_idx       <= 4'd14;
            gap_cnt       <= '0;
         end else if (state == SHIFT && bit_en) begin
            chan_b_serial <= frame_q[bit_idx];
            bit_idx       <= bit_idx - 4'd1;
         end else if (state == GAP && bit_en) begin
            chan_b_serial <= 1'b1;
            gap_cnt       <= gap_cnt + GW'(1);
         end
         if (last_bit) begin
            sent_valid <= 1'b1;
            sent_cmd   <= frame_q[13:6];
            if (frame_count != 32'hFFFF_FFFF)
               frame_count <= frame_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_ttc_chanb_transmitter.sv
// Directed bench for ttc_chanb_transmitter: table of single-command frames
// plus hand sequences for reset abort, priority and overwrite corners.
module tb_ttc_chanb_transmitter;

   localparam int GAP_BITS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bit_en = 1'b0;
   logic        req_evt_count_reset = 1'b0;
   logic        req_counter_reset = 1'b0;
   logic        req_fill_type = 1'b0;
   logic [1:0]  fill_type_sel = 2'b00;
   logic        req_pulse_storage = 1'b0;
   logic        pulse_storage_start = 1'b0;
   logic        chan_b_serial;
   logic        busy;
   logic [7:0]  sent_cmd;
   logic        sent_valid;
   logic [31:0] frame_count;
   logic [31:0] overwrite_count;

   ttc_chanb_transmitter #(.GAP_BITS(GAP_BITS)) dut (
      .clk                 (clk),
      .reset               (reset),
      .bit_en              (bit_en),
      .req_evt_count_reset (req_evt_count_reset),
      .req_counter_reset   (req_counter_reset),
      .req_fill_type       (req_fill_type),
      .fill_type_sel       (fill_type_sel),
      .req_pulse_storage   (req_pulse_storage),
      .pulse_storage_start (pulse_storage_start),
      .chan_b_serial       (chan_b_serial),
      .busy                (busy),
      .sent_cmd            (sent_cmd),
      .sent_valid          (sent_valid),
      .frame_count         (frame_count),
      .overwrite_count     (overwrite_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ecr;
      logic        cr;
      logic        ft;
      logic        ps;
      logic [1:0]  sel;
      logic        start;
      logic [7:0]  cmd;
      logic [15:0] frame;
   } vec_t;

   vec_t vecs[10];
   int   tests = 0;
   int   fails = 0;
   int   exp_fc = 0;
   int   exp_ow = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic req(input logic e, input logic c, input logic f,
                      input logic p, input logic [1:0] sel, input logic st);
      @(negedge clk);
      req_evt_count_reset = e;
      req_counter_reset   = c;
      req_fill_type       = f;
      req_pulse_storage   = p;
      fill_type_sel       = sel;
      pulse_storage_start = st;
      @(negedge clk);
      req_evt_count_reset = 1'b0;
      req_counter_reset   = 1'b0;
      req_fill_type       = 1'b0;
      req_pulse_storage   = 1'b0;
   endtask

   // one bit slot: strobe, sample after the edge, then three idle clocks
   task automatic bit_slot(input logic ecr_pulse, output logic s,
                           output logic v);
      @(negedge clk);
      bit_en = 1'b1;
      req_evt_count_reset = ecr_pulse;
      @(negedge clk);
      bit_en = 1'b0;
      req_evt_count_reset = 1'b0;
      s = chan_b_serial;
      v = sent_valid;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] exp_frame,
                             input logic [7:0] exp_cmd, input string tag,
                             input logic ecr_on_load);
      logic [15:0] got;
      logic [GAP_BITS-1:0] gap;
      logic s, v;
      int vcnt, vpos;
      got = '0;
      vcnt = 0;
      vpos = -1;
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bit_slot(ecr_on_load && i == 0, s, v);
         got = {got[14:0], s};
         if (v) begin
            vcnt++;
            vpos = i;
         end
      end
      exp_fc++;
      chk({tag, "_frame"}, 32'(got), 32'(exp_frame));
      chk({tag, "_cmd"}, 32'(sent_cmd), 32'(exp_cmd));
      chk({tag, "_valid_pos"}, 32'(vpos), 32'd15);
      chk({tag, "_valid_cnt"}, 32'(vcnt), 32'd1);
      chk({tag, "_fcount"}, frame_count, 32'(exp_fc));
      chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < GAP_BITS; i++) begin
         bit_slot(1'b0, s, v);
         gap[i] = s;
      end
      chk({tag, "_gap_ones"}, 32'(gap), 32'((1 << GAP_BITS) - 1));
      chk({tag, "_done_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic s, v;
      logic [15:0] f;
      logic [1:0] line_ok;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h02, 16'h009B};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h80, 16'h2039};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'hA0, 16'h2815};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'hC0, 16'h300D};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 8'hE0, 16'h3821};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h28, 16'h0A1F};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h2A, 16'h0A85};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h88, 16'h220B};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'hA8, 16'h2A27};
      vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'hC2, 16'h3097};

      repeat (3) @(negedge clk);
      chk("rst_serial", 32'(chan_b_serial), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd", 32'(sent_cmd), 32'd0);
      chk("rst_valid", 32'(sent_valid), 32'd0);
      chk("rst_fcount", frame_count, 32'd0);
      chk("rst_ocount", overwrite_count, 32'd0);

      // pending request without bit_en must not start a frame
      req(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
      repeat (10) @(negedge clk);
      chk("nobiten_busy", 32'(busy), 32'd0);
      chk("nobiten_serial", 32'(chan_b_serial), 32'd1);

      // abort at bit 7 of an A0 frame with a CR queued behind it
      f = 16'h2815;
      for (int i = 0; i < 7; i++)
         bit_slot(1'b0, s, v);
      chk("abort_bit7", 32'(s), 32'(f[9]));
      req(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      repeat (6) @(negedge clk);
      chk("hold_serial", 32'(chan_b_serial), 32'(f[9]));
      chk("hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_serial", 32'(chan_b_serial), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_fcount", frame_count, 32'd0);
      line_ok = 2'b11;
      for (int i = 0; i < 20; i++) begin
         bit_slot(1'b0, s, v);
         if (s !== 1'b1) line_ok[0] = 1'b0;
         if (busy !== 1'b0) line_ok[1] = 1'b0;
      end
      chk("abort_pend_clear", 32'(line_ok), 32'd3);

      foreach (vecs[i]) begin
         req(vecs[i].ecr, vecs[i].cr, vecs[i].ft, vecs[i].ps,
             vecs[i].sel, vecs[i].start);
         send_frame(vecs[i].frame, vecs[i].cmd, $sformatf("vec%0d", i), 1'b0);
      end
      chk("vec_ocount", overwrite_count, 32'(exp_ow));

      // CR absorbs ECR; FT follows in the next frame
      req(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
      send_frame(16'h0A85, 8'h2A, "prio_first", 1'b0);
      send_frame(16'h3821, 8'hE0, "prio_second", 1'b0);

      // second PS request overwrites the first before load
      req(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
      req(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      exp_ow++;
      chk("ow_count", overwrite_count, 32'(exp_ow));
      send_frame(16'h2A27, 8'hA8, "ow_frame", 1'b0);
      line_ok = 2'b11;
      for (int i = 0; i < 4; i++) begin
         bit_slot(1'b0, s, v);
         if (s !== 1'b1) line_ok[0] = 1'b0;
         if (busy !== 1'b0) line_ok[1] = 1'b0;
      end
      chk("ow_single_frame", 32'(line_ok), 32'd3);

      // ECR request on the very edge that clears ECR stays pending
      req(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      exp_ow++;
      send_frame(16'h009B, 8'h02, "same_clr_a", 1'b1);
      chk("same_clr_ocount", overwrite_count, 32'(exp_ow));
      send_frame(16'h009B, 8'h02, "same_clr_b", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
